// File: rtl/arb_pkg.sv
// Shared definitions for the parameterised arbiter.
//   arb_state_e : FSM encoding (IDLE, WAIT, GRANT), also visible on the bus
//                 interface as a debug field.
//   MODE_FIXED  : fixed priority, req[0] highest.
//   MODE_RR     : round-robin starting from a rotating pointer.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/param_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
//   req    : master -> slave, N_REQ request bits (pulse or level per channel)
//   gnt    : slave -> master, registered one-hot-or-zero grant
//   gnt_id : slave -> master, index of the current/last winner
//   busy   : slave -> master, high while a grant is in flight (WAIT/GRANT)
//   state  : slave -> master, FSM state for observation only
//
// Handshake: a channel requests by having req[i]=1 at any rising edge; the
// request is remembered until served, and repeated requests on a channel that
// is still waiting merge into one. The arbiter answers with gnt[i] high for a
// fixed number of cycles a fixed number of edges after it picks the channel.
// There is no back-pressure: the requester does not hold req for acceptance.
interface param_arbiter_if #(
  parameter int N_REQ = 4
);
  import arb_pkg::*;

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         gnt;
  logic [$clog2(N_REQ)-1:0] gnt_id;
  logic                     busy;
  arb_state_e               state;

  modport master (output req, input gnt, input gnt_id, input busy, input state);
  modport slave  (input req, output gnt, output gnt_id, output busy, output state);

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   vec   : candidate request vector
//   ptr   : round-robin start index (ignored when mode=0)
//   mode  : 0 = lowest set index wins, 1 = first set index at or above ptr,
//           wrapping from N-1 back to 0
//   valid : at least one bit of vec is set
//   index : winning channel index (0 when valid=0)
module arb_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 mode,
  output logic                 valid,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  int            j;

  // Walk the vector starting at the base index; the first hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (mode ? int'(ptr) : 0) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!valid && vec[idx]) begin
        valid = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/param_arbiter.sv
// Parameterised delayed-grant arbiter.
//   clock : sole clock, rising edge
//   rst   : synchronous, active-high reset
//   bus   : param_arbiter_if slave modport (req in; gnt, gnt_id, busy, state out)
// Parameters: N_REQ requesters (2..16), GNT_DELAY edges from capture to grant
// (3..7), GNT_LEN grant width in cycles (1..2), MODE fixed priority or
// round-robin.
//
// Requests are latched into a pending register. From IDLE the arbiter picks a
// winner among pending|req, waits GNT_DELAY edges, drives gnt for GNT_LEN
// cycles and returns to IDLE, which guarantees a low gap between grants.
module param_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int GNT_DELAY = 3,
  parameter int GNT_LEN   = 1,
  parameter int MODE      = MODE_FIXED
) (
  input  logic           clock,
  input  logic           rst,
  param_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(GNT_DELAY + GNT_LEN + 1);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] win_mask;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] gnt_next;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    next_ptr;
  logic [IW-1:0]    gnt_id_q;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             capture;
  logic             busy;
  logic [CW-1:0]    cnt;

  // A request arriving on the capture edge competes immediately.
  assign cand    = pending | bus.req;
  assign capture = (state == IDLE) && pick_valid;

  arb_pick #(
    .N (N_REQ)
  ) u_pick (
    .vec   (cand),
    .ptr   (ptr),
    .mode  (MODE == MODE_RR),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    win_mask           = '0;
    win_mask[pick_idx] = 1'b1;
    next_ptr           = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM: next state. cnt counts down to zero in WAIT and in GRANT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = WAIT;
      WAIT:    if (cnt == '0)  state_next = GRANT;
      GRANT:   if (cnt == '0)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. gnt is computed for the next state and registered below,
  // so gnt has no combinational path from req.
  always_comb begin
    gnt_next = '0;
    if (state_next == GRANT) gnt_next[gnt_id_q] = 1'b1;
    busy = (state != IDLE);
  end

  // Datapath: pending, pointer, winner id, delay counter, grant register.
  always_ff @(posedge clock) begin
    if (rst) begin
      pending  <= '0;
      ptr      <= '0;
      gnt_id_q <= '0;
      cnt      <= '0;
      gnt_q    <= '0;
    end else begin
      if (capture) begin
        // The winner's bit is cleared even if it requests again this edge;
        // requests on later edges set it again and earn a second grant.
        pending  <= cand & ~win_mask;
        gnt_id_q <= pick_idx;
        ptr      <= next_ptr;
      end else begin
        pending <= cand;
      end

      // Loaded with DELAY-1 at capture so GRANT starts GNT_DELAY edges later;
      // reloaded with LEN-1 on entering GRANT for GNT_LEN grant cycles.
      case (state)
        IDLE:    if (pick_valid) cnt <= CW'(GNT_DELAY - 1);
        WAIT:    if (cnt == '0) cnt <= CW'(GNT_LEN - 1);
                 else           cnt <= cnt - 1'b1;
        GRANT:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= '0;
      endcase

      gnt_q <= gnt_next;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy;
  assign bus.state  = state;

endmodule

// File: tb/tb_param_arbiter.sv
// Directed bench for param_arbiter. Four instances share clock and reset:
//   u_fix  : N=4, delay 3, len 1, fixed priority
//   u_rr   : N=4, delay 3, len 1, round-robin
//   u_long : N=4, delay 7, len 2, fixed priority
//   u_rnd  : N=8, delay 3, len 1, round-robin, random traffic
// Edge E below is the rising edge at which a request is sampled; outputs are
// sampled 1 time unit after each edge.
module tb_param_arbiter;
  import arb_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  param_arbiter_if #(.N_REQ(4)) fix_if ();
  param_arbiter_if #(.N_REQ(4)) rr_if ();
  param_arbiter_if #(.N_REQ(4)) long_if ();
  param_arbiter_if #(.N_REQ(8)) rnd_if ();

  param_arbiter #(.N_REQ(4), .GNT_DELAY(3), .GNT_LEN(1), .MODE(MODE_FIXED)) u_fix (
    .clock (clock), .rst (rst), .bus (fix_if.slave));
  param_arbiter #(.N_REQ(4), .GNT_DELAY(3), .GNT_LEN(1), .MODE(MODE_RR)) u_rr (
    .clock (clock), .rst (rst), .bus (rr_if.slave));
  param_arbiter #(.N_REQ(4), .GNT_DELAY(7), .GNT_LEN(2), .MODE(MODE_FIXED)) u_long (
    .clock (clock), .rst (rst), .bus (long_if.slave));
  param_arbiter #(.N_REQ(8), .GNT_DELAY(3), .GNT_LEN(1), .MODE(MODE_RR)) u_rnd (
    .clock (clock), .rst (rst), .bus (rnd_if.slave));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Capture edge for u_fix: busy must be high and the winner id loaded.
  task automatic fix_capture(input string tag, input logic [1:0] exp_id);
    tick();
    check({tag, "_busy"}, fix_if.busy, 1);
    check({tag, "_id"}, fix_if.gnt_id, exp_id);
  endtask

  // From a capture edge E: gnt low at E+1,E+2, exp_gnt at E+3, low and IDLE at E+4.
  task automatic fix_grant(input string tag, input logic [3:0] exp_gnt);
    for (int k = 0; k < 2; k++) begin
      tick();
      check({tag, "_wait_gnt"}, fix_if.gnt, 4'b0000);
      check({tag, "_wait_busy"}, fix_if.busy, 1);
    end
    tick();
    check({tag, "_gnt"}, fix_if.gnt, exp_gnt);
    check({tag, "_gnt_busy"}, fix_if.busy, 1);
    tick();
    check({tag, "_after_gnt"}, fix_if.gnt, 4'b0000);
    check({tag, "_after_state"}, fix_if.state, IDLE);
  endtask

  int         last_req[8];
  int         last_gnt[8];
  logic [7:0] prev_g;
  logic [7:0] g;
  logic [7:0] bhist;
  int         run;
  int         last_rise;

  initial begin
    fix_if.req  = '0;
    rr_if.req   = '0;
    long_if.req = '0;
    rnd_if.req  = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_fix_gnt", fix_if.gnt, 0);
    check("rst_fix_id", fix_if.gnt_id, 0);
    check("rst_fix_busy", fix_if.busy, 0);
    check("rst_fix_state", fix_if.state, IDLE);
    check("rst_rr_gnt", rr_if.gnt, 0);
    check("rst_long_busy", long_if.busy, 0);
    check("rst_rnd_gnt", rnd_if.gnt, 0);
    rst = 1'b0;
    tick();

    // Single pulse on channel 0: grant only at E+3.
    fix_if.req = 4'b0001;
    tick();
    fix_if.req = '0;
    check("p0_cap_busy", fix_if.busy, 1);
    check("p0_cap_gnt", fix_if.gnt, 0);
    check("p0_cap_id", fix_if.gnt_id, 0);
    fix_grant("p0", 4'b0001);
    check("p0_idle_busy", fix_if.busy, 0);

    // Two requests at once: channel 1 first, then channel 3 at E+8.
    fix_if.req = 4'b1010;
    tick();
    fix_if.req = '0;
    check("pr_cap_id", fix_if.gnt_id, 1);
    fix_grant("pr_a", 4'b0010);
    fix_capture("pr_b_cap", 2'd3);
    fix_grant("pr_b", 4'b1000);
    tick();
    check("pr_done_busy", fix_if.busy, 0);
    check("pr_hold_id", fix_if.gnt_id, 3);

    // Re-request of the channel in WAIT yields a second grant.
    fix_if.req = 4'b0100;
    tick();
    fix_if.req = '0;
    tick();
    fix_if.req = 4'b0100;
    tick();
    fix_if.req = '0;
    tick();
    check("rr2_first_gnt", fix_if.gnt, 4'b0100);
    tick();
    check("rr2_gap", fix_if.gnt, 4'b0000);
    fix_capture("rr2_again", 2'd2);
    fix_grant("rr2_second", 4'b0100);
    tick();
    check("rr2_idle", fix_if.busy, 0);

    // Requests arriving in WAIT are kept and served by priority afterwards.
    fix_if.req = 4'b0100;
    tick();
    fix_if.req = 4'b1001;
    tick();
    fix_if.req = '0;
    tick();
    tick();
    check("late_first", fix_if.gnt, 4'b0100);
    tick();
    check("late_gap", fix_if.gnt, 4'b0000);
    fix_capture("late_cap0", 2'd0);
    fix_grant("late_g0", 4'b0001);
    fix_capture("late_cap3", 2'd3);
    fix_grant("late_g3", 4'b1000);
    tick();
    check("late_idle", fix_if.busy, 0);

    // Reset during WAIT aborts the grant and drops pending requests.
    fix_if.req = 4'b0010;
    tick();
    fix_if.req = 4'b1000;
    tick();
    fix_if.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_gnt", fix_if.gnt, 0);
    check("abort_busy", fix_if.busy, 0);
    check("abort_state", fix_if.state, IDLE);
    check("abort_pending", u_fix.pending, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort_no_gnt", {fix_if.busy, fix_if.gnt}, 0);
    end

    // req is ignored on a reset edge.
    rst = 1'b1;
    fix_if.req = 4'b0001;
    tick();
    rst = 1'b0;
    fix_if.req = '0;
    tick();
    check("rst_req_busy", fix_if.busy, 0);
    check("rst_req_pending", u_fix.pending, 0);

    // Round-robin, all channels held: order 0,1,2,3,0, one grant per 5 edges.
    rr_if.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      check("rr_pre_gnt", rr_if.gnt, 0);
      tick();
      check("rr_order_gnt", rr_if.gnt, 4'b0001 << (k % 4));
      check("rr_order_id", rr_if.gnt_id, k % 4);
      tick();
      check("rr_gap", rr_if.gnt, 0);
      tick();
    end
    rr_if.req = '0;
    for (int k = 0; k < 30; k++) tick();
    check("rr_drained", rr_if.busy, 0);

    // Delay 7, length 2: req[2] at edge 0, req[0] at edge 2.
    long_if.req = 4'b0100;
    tick();
    long_if.req = '0;
    check("long_cap_id", long_if.gnt_id, 2);
    tick();
    long_if.req = 4'b0001;
    tick();
    long_if.req = '0;
    for (int e = 3; e <= 19; e++) begin
      tick();
      if (e == 7 || e == 8)        check("long_gnt", long_if.gnt, 4'b0100);
      else if (e == 17 || e == 18) check("long_gnt", long_if.gnt, 4'b0001);
      else                         check("long_gnt", long_if.gnt, 4'b0000);
      if (e == 10) check("long_cap2_id", long_if.gnt_id, 0);
      if (e == 9)  check("long_gap_state", long_if.state, IDLE);
    end
    check("long_idle", long_if.busy, 0);

    // Reset in the middle of a two-cycle grant.
    long_if.req = 4'b0010;
    tick();
    long_if.req = '0;
    for (int k = 0; k < 7; k++) tick();
    check("lrst_gnt_on", long_if.gnt, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("lrst_gnt_off", long_if.gnt, 0);
    check("lrst_busy", long_if.busy, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("lrst_quiet", long_if.gnt, 0);
    end

    // Random traffic on 8 channels, then a quiet drain.
    for (int i = 0; i < 8; i++) begin
      last_req[i] = -1;
      last_gnt[i] = -1;
    end
    prev_g    = '0;
    bhist     = '0;
    run       = 0;
    last_rise = -100;
    for (int n = 0; n < 3060; n++) begin
      if (n < 3000 && $urandom_range(0, 2) == 0) rnd_if.req = 8'($urandom_range(0, 255));
      else                                       rnd_if.req = '0;
      tick();
      for (int i = 0; i < 8; i++) if (rnd_if.req[i]) last_req[i] = n;
      g = rnd_if.gnt;
      check("rnd_onehot", $countones(g) <= 1, 1);
      if (g != 0 && prev_g == 0) begin
        check("rnd_gnt_id", g, 8'(1) << rnd_if.gnt_id);
        check("rnd_spacing", (n - last_rise) >= 5, 1);
        // busy low before the capture edge, high for the three edges after it
        check("rnd_delay", bhist[3:0], 4'b0111);
        last_rise = n;
        run = 1;
        for (int i = 0; i < 8; i++) if (g[i]) last_gnt[i] = n;
      end else if (g != 0) begin
        check("rnd_hold", g, prev_g);
        run++;
      end else if (prev_g != 0) begin
        check("rnd_len", run, 1);
      end
      bhist  = {bhist[6:0], rnd_if.busy};
      prev_g = g;
    end
    check("rnd_drained", rnd_if.busy, 0);
    for (int i = 0; i < 8; i++) begin
      if (last_req[i] >= 0) check("rnd_served", last_gnt[i] > last_req[i], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
